// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo counter: end-of-range mode encodings and
// the run/done state type.
package cnt_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational step logic for mod_counter: terminal detection, the count an
// enabled edge would produce, and the clamped load value.
module mod_counter_next
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MOD   = 16
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             up_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o,
    output logic [WIDTH-1:0] step_cnt_o,
    output logic             step_wrap_o,
    output logic             step_done_o,
    output logic [WIDTH-1:0] load_cnt_o
);

    localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] MOD_C = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0] ONE_C = (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] step_ext;

    assign cnt_ext  = {1'b0, cnt_i};
    assign load_ext = {1'b0, load_val_i};

    assign tc_o = up_i ? (cnt_ext == MAX_C) : (cnt_ext == '0);

    always_comb begin
        step_ext    = cnt_ext;
        step_wrap_o = 1'b0;
        step_done_o = 1'b0;
        if (!tc_o) begin
            step_ext = up_i ? (cnt_ext + ONE_C) : (cnt_ext - ONE_C);
        end else begin
            case (mode_i)
                MODE_SAT: begin
                    step_ext = cnt_ext;
                end
                MODE_ONESHOT: begin
                    step_ext    = cnt_ext;
                    step_done_o = 1'b1;
                end
                default: begin
                    // Reserved encoding falls through to wrap behaviour.
                    step_ext    = up_i ? '0 : MAX_C;
                    step_wrap_o = 1'b1;
                end
            endcase
        end
    end

    // Guard keeps a non-power-of-two modulus from ever leaking an out-of-range value.
    assign step_cnt_o = (step_ext < MOD_C) ? step_ext[WIDTH-1:0] : MAX_C[WIDTH-1:0];
    assign load_cnt_o = (load_ext >= MOD_C) ? MAX_C[WIDTH-1:0] : load_val_i;

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with wrap, saturate and one-shot
// end-of-range modes; holds the registers and the run/done FSM.
module mod_counter
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MOD   = 16,
    parameter longint unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_done,
    output cnt_state_e       o_state
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 2..32");
    end
    if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
    if (INIT >= MOD) begin : g_bad_init
        $error("mod_counter: INIT must be below MOD");
    end

    localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT);

    logic [WIDTH-1:0] cnt_q;
    logic             wrap_q;
    logic             done_q;
    cnt_state_e       state_q;

    logic [WIDTH-1:0] step_cnt_d;
    logic             step_wrap_d;
    logic             step_done_d;
    logic [WIDTH-1:0] load_cnt_d;
    logic             tc;

    mod_counter_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .cnt_i       (cnt_q),
        .up_i        (i_up),
        .mode_i      (i_mode),
        .load_val_i  (i_load_val),
        .tc_o        (tc),
        .step_cnt_o  (step_cnt_d),
        .step_wrap_o (step_wrap_d),
        .step_done_o (step_done_d),
        .load_cnt_o  (load_cnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= INIT_C;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
        end else if (i_clr) begin
            cnt_q   <= INIT_C;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
        end else if (i_load) begin
            cnt_q   <= load_cnt_d;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
        end else if (i_en && state_q == ST_RUN) begin
            cnt_q  <= step_cnt_d;
            wrap_q <= step_wrap_d;
            if (step_done_d) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
            end
        end else begin
            // Holding (disabled, or parked in DONE) never produces a wrap pulse.
            wrap_q <= 1'b0;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_tc    = tc;
    assign o_wrap  = wrap_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed and randomised bench for mod_counter (WIDTH=4, MOD=10) against an
// arithmetic reference model of the counting rules.
module tb_mod_counter;
    import cnt_pkg::*;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int INIT  = 0;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             wrap;
    logic             done;
    cnt_state_e       state;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt;
    int m_wrap;
    int m_done;
    logic [WIDTH-1:0] exp_q[$];

    mod_counter #(
        .WIDTH (WIDTH),
        .MOD   (MOD),
        .INIT  (INIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_up       (up),
        .i_mode     (mode),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .o_cnt      (cnt),
        .o_tc       (tc),
        .o_wrap     (wrap),
        .o_done     (done),
        .o_state    (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    task automatic model_reset();
        m_cnt  = INIT;
        m_wrap = 0;
        m_done = 0;
        exp_q.push_back(WIDTH'(m_cnt));
    endtask

    task automatic model_edge();
        int nxt;
        int lv;
        if (clr) begin
            m_cnt = INIT; m_wrap = 0; m_done = 0;
        end else if (load) begin
            lv = int'(load_val);
            m_cnt = (lv > MOD - 1) ? MOD - 1 : lv;
            m_wrap = 0; m_done = 0;
        end else if (en && m_done == 0) begin
            nxt = up ? m_cnt + 1 : m_cnt - 1;
            if (nxt >= 0 && nxt < MOD) begin
                m_cnt = nxt; m_wrap = 0;
            end else if (mode == 2'b01) begin
                m_wrap = 0;
            end else if (mode == 2'b10) begin
                m_done = 1; m_wrap = 0;
            end else begin
                m_cnt = (nxt + MOD) % MOD; m_wrap = 1;
            end
        end else begin
            m_wrap = 0;
        end
        exp_q.push_back(WIDTH'(m_cnt));
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] e_cnt;
        e_cnt = '0;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e_cnt = exp_q.pop_front();
        end
        chk({tag, ".cnt"},   32'(cnt),   32'(e_cnt));
        chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".tc"},    32'(tc),    32'(up ? (m_cnt == MOD - 1) : (m_cnt == 0)));
        chk({tag, ".state"}, 32'(state), 32'(m_done != 0 ? ST_DONE : ST_RUN));
    endtask

    // driver
    task automatic drive(input logic e, input logic u, input logic [1:0] md,
                         input logic c, input logic l, input logic [WIDTH-1:0] v);
        en = e; up = u; mode = md; clr = c; load = l; load_val = v;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b0, '0);
        model_reset();
        #4;
        check_all("rst_hold");
        #16;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_all("rst_release");

        drive(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) tick("wrap_up");

        drive(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd1);
        tick("wrap_dn_load");
        drive(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) tick("wrap_dn");

        drive(1'b0, 1'b1, MODE_SAT, 1'b0, 1'b1, 4'd7);
        tick("sat_load");
        drive(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick("sat");

        drive(1'b0, 1'b1, MODE_ONESHOT, 1'b0, 1'b1, 4'd8);
        tick("os_load");
        drive(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) tick("oneshot");
        drive(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b1, 4'd3);
        tick("os_reload");
        drive(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) tick("os_resume");

        drive(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd12);
        tick("clamp12");
        drive(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd15);
        tick("clamp15");
        drive(1'b1, 1'b1, MODE_WRAP, 1'b1, 1'b1, 4'd5);
        tick("clr_load");
        drive(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd9);
        tick("term_load");
        drive(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd2);
        tick("load_en_term");

        drive(1'b0, 1'b1, MODE_WRAP, 1'b1, 1'b0, '0);
        tick("pre_rst_clr");
        drive(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) tick("to_seven");
        async_reset("rst_mid");
        tick("post_rst");

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), (r < 3), (r >= 3 && r < 10),
                  WIDTH'($urandom_range(0, 15)));
            if (r == 99) async_reset("rnd_rst");
            else tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
